mem_wb_pipe: RTL and testbench
==============================

Name: mem_wb_pipe

Overview:
Parametrised successor to the single-stage MEM/WB flop bank. It carries writeback-bound data (memory read data, ALU result, PC+2, B operand, RegSrc select, RegWrt, destination register) through DEPTH registered stages. It adds a per-stage valid bit, stall (hold), flush (bubble insert) and a combinational RAW-hazard lookup across all stages. It sits between the MEM stage / EX_MEM register and the wb mux and register file.

Parameters:
DATA_W, 16, width of each data field (mem, alu, pc, Binput)
REG_W, 3, width of register-file address
DEPTH, 1, number of pipeline stages (legal 1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold all stages unchanged
flush  in  1  invalidate all stages, insert bubble
valid_in  in  1  input bundle is a real instruction
RegSrc_in  in  2  wb mux select
MemRead_in  in  DATA_W  data read from memory
alu_data_in  in  DATA_W  ALU result
pc_data_in  in  DATA_W  PC+2 for link writes
Binput_in  in  DATA_W  B operand passthrough
RegWrt_in  in  1  register write enable
WrtReg_in  in  REG_W  destination register
rd_addr_a  in  REG_W  source reg A to check for hazard
rd_addr_b  in  REG_W  source reg B to check for hazard
valid_out  out  1  last stage holds a real instruction
RegSrc_out  out  2  last-stage RegSrc
mem_data_out  out  DATA_W  last-stage mem data
alu_data_out  out  DATA_W  last-stage ALU result
pc_data_out  out  DATA_W  last-stage PC+2
Binput_out  out  DATA_W  last-stage B operand
RegWrt_out  out  1  last-stage RegWrt AND valid
WrtReg_out  out  REG_W  last-stage destination
hit_a  out  1  some valid stage will write rd_addr_a
hit_b  out  1  some valid stage will write rd_addr_b

Behaviour:
- Stages S0..S(DEPTH-1). Each stage holds: valid, RegSrc, 4 data fields, RegWrt, WrtReg. Outputs come directly from S(DEPTH-1), with no combinational path from inputs to data outputs. Latency is DEPTH cycles.
- rst=1 at an edge: every stage valid=0 and every field=0. All outputs therefore read 0 the cycle after reset. Reset overrides stall and flush.
- Normal edge (rst=0, flush=0, stall=0): S0 loads the input bundle with valid=valid_in. Sk loads S(k-1) for k≥1.
- stall=1, flush=0: every stage holds its value. Input bundle and valid_in are ignored, so the bundle is dropped; upstream must hold it.
- flush=1: every stage gets valid=0 and RegWrt=0. Flush overrides stall. Without the optional feature, data fields advance as on a normal edge and the input bundle is discarded as a bubble.
- valid_in=0 on a normal edge: S0 gets valid=0 and RegWrt=0 (RegWrt stored gated).
- RegWrt_out = RegWrt(S last) & valid(S last). A bubble never writes the register file.
- hit_a is combinational: OR over k of (valid_k & RegWrt_k & WrtReg_k==rd_addr_a). hit_b is the same using rd_addr_b. Register 0 is not special.
- hit_a and hit_b reflect current stage contents, including during stall. After flush they are 0 in the following cycle.
- DEPTH=1 with stall=flush=0 and valid_in=1 is cycle-identical to the legacy flop bank on the shared fields.
- Simultaneous reset with flush or stall: reset wins.

Optional Feature:
MEM_WB_CLR_DATA_EN
- Defined: any stage entry made invalid (flush, or valid_in=0 into S0) also zeroes RegSrc, all DATA_W fields and WrtReg. A bubble is then all-zero, for debug and trace.
- Undefined: only valid and RegWrt are cleared and data fields carry stale values. This saves enable muxing.
- Ports and timing are identical either way.

Test Plan:
- Reset: hold rst=1 for 2 cycles with inputs at 0xFFFF -> all outputs 0, valid_out=0, hit_a=hit_b=0.
- Latency, DEPTH=2: drive alu_data_in=0x1234, WrtReg_in=5, RegWrt_in=1, valid_in=1 for one cycle -> alu_data_out=0x1234 and RegWrt_out=1 exactly 2 cycles later, then RegWrt_out=0 with valid_in=0.
- Stall: load 0xAAAA, assert stall for 3 cycles while inputs change to 0x5555 -> outputs remain 0xAAAA through the stall; 0x5555 is never captured.
- Flush over stall: with valid stages writing reg 3, assert stall=1 and flush=1 together -> next cycle valid_out=0, RegWrt_out=0, hit_a=0 with rd_addr_a=3.
- Hazard: S0 holds WrtReg=4/RegWrt=1 and S1 holds WrtReg=2/RegWrt=0, with rd_addr_a=4 and rd_addr_b=2 -> hit_a=1, hit_b=0.
- MEM_WB_CLR_DATA_EN defined: flush after loading mem data 0xBEEF -> mem_data_out=0x0000. Undefined: valid_out=0 with data not checked.

Source files
------------

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register: DEPTH registered stages of writeback-bound data, each with a valid bit.
// Latency DEPTH cycles; outputs come straight from the last stage, hit_a/hit_b are combinational.
// Backpressure: stall holds every stage and drops the input bundle; flush turns every stage into a bubble, even under stall.
//
// Ports:
//   clk, rst         - clock and synchronous active-high reset (all stages cleared; wins over stall/flush)
//   stall, flush     - hold all stages / invalidate all stages
//   valid_in + *_in  - input bundle from the MEM stage
//   *_out            - last-stage bundle (RegWrt_out is gated by valid_out)
//   rd_addr_a/b      - source registers checked for RAW hazards
//   hit_a/b          - some valid stage will write rd_addr_a/b
//
// Build option: define MEM_WB_CLR_DATA_EN to zero every field of a stage entry
// made invalid, so bubbles are all-zero in traces. Ports and timing are unchanged.

module mem_wb_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_W  = 3,
    parameter int unsigned DEPTH  = 1       // legal range 1..4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [1:0]        RegSrc_in,
    input  logic [DATA_W-1:0] MemRead_in,
    input  logic [DATA_W-1:0] alu_data_in,
    input  logic [DATA_W-1:0] pc_data_in,
    input  logic [DATA_W-1:0] Binput_in,
    input  logic              RegWrt_in,
    input  logic [REG_W-1:0]  WrtReg_in,
    input  logic [REG_W-1:0]  rd_addr_a,
    input  logic [REG_W-1:0]  rd_addr_b,
    output logic              valid_out,
    output logic [1:0]        RegSrc_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] alu_data_out,
    output logic [DATA_W-1:0] pc_data_out,
    output logic [DATA_W-1:0] Binput_out,
    output logic              RegWrt_out,
    output logic [REG_W-1:0]  WrtReg_out,
    output logic              hit_a,
    output logic              hit_b
);

    typedef struct packed {
        logic              valid;
        logic [1:0]        reg_src;
        logic [DATA_W-1:0] mem_dat;
        logic [DATA_W-1:0] alu_dat;
        logic [DATA_W-1:0] pc_dat;
        logic [DATA_W-1:0] b_dat;
        logic              reg_wrt;
        logic [REG_W-1:0]  wrt_reg;
    } stage_t;

    stage_t stg_q [DEPTH];
    stage_t stg_d [DEPTH];
    stage_t in_stage;

    // Turn an entry into a bubble. By default only the control bits are
    // cleared and the data fields keep whatever stale value they carried.
    function automatic stage_t to_bubble(input stage_t s);
        stage_t b;
        b         = s;
        b.valid   = 1'b0;
        b.reg_wrt = 1'b0;
`ifdef MEM_WB_CLR_DATA_EN
        b.reg_src = '0;
        b.mem_dat = '0;
        b.alu_dat = '0;
        b.pc_dat  = '0;
        b.b_dat   = '0;
        b.wrt_reg = '0;
`endif
        return b;
    endfunction

    always_comb begin
        in_stage.valid   = valid_in;
        in_stage.reg_src = RegSrc_in;
        in_stage.mem_dat = MemRead_in;
        in_stage.alu_dat = alu_data_in;
        in_stage.pc_dat  = pc_data_in;
        in_stage.b_dat   = Binput_in;
        // RegWrt is stored already gated so a non-instruction can never write.
        in_stage.reg_wrt = RegWrt_in & valid_in;
        in_stage.wrt_reg = WrtReg_in;
    end

    // Next-state for an advancing edge (normal or flush). Flush advances the
    // data like a normal edge but makes every entry a bubble.
    always_comb begin
        stg_d[0] = (flush || !valid_in) ? to_bubble(in_stage) : in_stage;
        for (int k = 1; k < int'(DEPTH); k++) begin
            stg_d[k] = flush ? to_bubble(stg_q[k-1]) : stg_q[k-1];
        end
    end

    // Flush takes priority over stall, so a flushed pipe always advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stg_q[k] <= '0;
            end
        end else if (flush || !stall) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                stg_q[k] <= stg_d[k];
            end
        end
    end

    assign valid_out    = stg_q[DEPTH-1].valid;
    assign RegSrc_out   = stg_q[DEPTH-1].reg_src;
    assign mem_data_out = stg_q[DEPTH-1].mem_dat;
    assign alu_data_out = stg_q[DEPTH-1].alu_dat;
    assign pc_data_out  = stg_q[DEPTH-1].pc_dat;
    assign Binput_out   = stg_q[DEPTH-1].b_dat;
    assign RegWrt_out   = stg_q[DEPTH-1].reg_wrt & stg_q[DEPTH-1].valid;
    assign WrtReg_out   = stg_q[DEPTH-1].wrt_reg;

    // RAW hazard lookup over every stage; register 0 gets no special treatment.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            hit_a = hit_a | (stg_q[k].valid & stg_q[k].reg_wrt & (stg_q[k].wrt_reg == rd_addr_a));
            hit_b = hit_b | (stg_q[k].valid & stg_q[k].reg_wrt & (stg_q[k].wrt_reg == rd_addr_b));
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Bench for mem_wb_pipe at DEPTH=2: directed scenarios plus random traffic.
// Expected stage contents are pushed into a queue as stimulus is applied and popped as they leave the pipe.
// Stall, flush and reset are all exercised, including in combination.

module tb_mem_wb_pipe;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst, stall, flush, valid_in;
    logic [1:0]        RegSrc_in;
    logic [DATA_W-1:0] MemRead_in, alu_data_in, pc_data_in, Binput_in;
    logic              RegWrt_in;
    logic [REG_W-1:0]  WrtReg_in, rd_addr_a, rd_addr_b;
    logic              valid_out;
    logic [1:0]        RegSrc_out;
    logic [DATA_W-1:0] mem_data_out, alu_data_out, pc_data_out, Binput_out;
    logic              RegWrt_out;
    logic [REG_W-1:0]  WrtReg_out;
    logic              hit_a, hit_b;

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .RegSrc_in(RegSrc_in), .MemRead_in(MemRead_in), .alu_data_in(alu_data_in),
        .pc_data_in(pc_data_in), .Binput_in(Binput_in), .RegWrt_in(RegWrt_in),
        .WrtReg_in(WrtReg_in), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .valid_out(valid_out), .RegSrc_out(RegSrc_out), .mem_data_out(mem_data_out),
        .alu_data_out(alu_data_out), .pc_data_out(pc_data_out), .Binput_out(Binput_out),
        .RegWrt_out(RegWrt_out), .WrtReg_out(WrtReg_out), .hit_a(hit_a), .hit_b(hit_b)
    );

    typedef struct packed {
        logic              vld;
        logic [1:0]        src;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] b;
        logic              wrt;
        logic [REG_W-1:0]  wreg;
    } ent_t;

    // Front = last stage (what the outputs show), back = S0.
    ent_t pipe_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t kill(input ent_t e);
        ent_t r;
        r     = e;
        r.vld = 1'b0;
        r.wrt = 1'b0;
`ifdef MEM_WB_CLR_DATA_EN
        r = '0;
`endif
        return r;
    endfunction

    function automatic ent_t input_ent();
        ent_t e;
        e.vld  = valid_in;
        e.src  = RegSrc_in;
        e.mem  = MemRead_in;
        e.alu  = alu_data_in;
        e.pc   = pc_data_in;
        e.b    = Binput_in;
        e.wrt  = RegWrt_in;
        e.wreg = WrtReg_in;
        return e;
    endfunction

    // Reference behaviour at one rising edge, using the inputs present at that edge.
    task automatic model_edge();
        ent_t e;
        if (rst) begin
            pipe_q.delete();
            for (int i = 0; i < DEPTH; i++) pipe_q.push_back('0);
        end else if (flush) begin
            pipe_q.push_back(input_ent());
            void'(pipe_q.pop_front());
            foreach (pipe_q[i]) pipe_q[i] = kill(pipe_q[i]);
        end else if (!stall) begin
            e = input_ent();
            if (!e.vld) e = kill(e);
            pipe_q.push_back(e);
            void'(pipe_q.pop_front());
        end
    endtask

    task automatic compare_all();
        ent_t e;
        logic ha, hb;
        e  = pipe_q[0];
        ha = 1'b0;
        hb = 1'b0;
        foreach (pipe_q[i]) begin
            if (pipe_q[i].vld && pipe_q[i].wrt && pipe_q[i].wreg == rd_addr_a) ha = 1'b1;
            if (pipe_q[i].vld && pipe_q[i].wrt && pipe_q[i].wreg == rd_addr_b) hb = 1'b1;
        end
        chk_val("valid_out",  32'(valid_out),    32'(e.vld));
        chk_val("RegSrc_out", 32'(RegSrc_out),   32'(e.src));
        chk_val("mem_out",    32'(mem_data_out), 32'(e.mem));
        chk_val("alu_out",    32'(alu_data_out), 32'(e.alu));
        chk_val("pc_out",     32'(pc_data_out),  32'(e.pc));
        chk_val("b_out",      32'(Binput_out),   32'(e.b));
        chk_val("RegWrt_out", 32'(RegWrt_out),   32'(e.wrt & e.vld));
        chk_val("WrtReg_out", 32'(WrtReg_out),   32'(e.wreg));
        chk_val("hit_a",      32'(hit_a),        32'(ha));
        chk_val("hit_b",      32'(hit_b),        32'(hb));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic v, input logic w, input logic [REG_W-1:0] wr,
                          input logic [1:0] src, input logic [DATA_W-1:0] d);
        valid_in    = v;
        RegWrt_in   = w;
        WrtReg_in   = wr;
        RegSrc_in   = src;
        MemRead_in  = d;
        alu_data_in = d;
        pc_data_in  = d;
        Binput_in   = d;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) pipe_q.push_back('0);
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        rd_addr_a = 3'd7; rd_addr_b = 3'd7;
        set_in(1'b1, 1'b1, 3'd7, 2'd3, 16'hFFFF);
        #2;

        // Reset with all-ones inputs.
        step();
        step();
        chk_val("rst_valid", 32'(valid_out), 32'd0);
        chk_val("rst_alu",   32'(alu_data_out), 32'd0);
        chk_val("rst_hit_a", 32'(hit_a), 32'd0);

        // Latency: one instruction, then bubbles.
        rst = 1'b0;
        set_in(1'b1, 1'b1, 3'd5, 2'd1, 16'h0000);
        alu_data_in = 16'h1234;
        step();
        chk_val("lat_early_valid", 32'(valid_out), 32'd0);
        valid_in = 1'b0;
        step();
        chk_val("lat_alu",    32'(alu_data_out), 32'h1234);
        chk_val("lat_regwrt", 32'(RegWrt_out), 32'd1);
        step();
        chk_val("lat_bubble_regwrt", 32'(RegWrt_out), 32'd0);

        // Stall holds 0xAAAA while 0x5555 sits on the inputs.
        set_in(1'b1, 1'b1, 3'd1, 2'd2, 16'hAAAA);
        step();
        step();
        set_in(1'b1, 1'b1, 3'd6, 2'd0, 16'h5555);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_val("stall_hold", 32'(alu_data_out), 32'hAAAA);
        end
        stall = 1'b0;
        set_in(1'b1, 1'b1, 3'd6, 2'd0, 16'h7777);
        step();
        chk_val("stall_release", 32'(alu_data_out), 32'hAAAA);
        step();
        chk_val("stall_no_5555", 32'(alu_data_out), 32'h7777);

        // Flush together with stall.
        set_in(1'b1, 1'b1, 3'd3, 2'd0, 16'h0033);
        rd_addr_a = 3'd3;
        step();
        step();
        chk_val("pre_flush_hit_a", 32'(hit_a), 32'd1);
        stall = 1'b1; flush = 1'b1;
        step();
        chk_val("flush_valid",  32'(valid_out), 32'd0);
        chk_val("flush_regwrt", 32'(RegWrt_out), 32'd0);
        chk_val("flush_hit_a",  32'(hit_a), 32'd0);
        stall = 1'b0; flush = 1'b0;

        // Hazard: S1 = reg 2 no write, S0 = reg 4 write.
        set_in(1'b1, 1'b0, 3'd2, 2'd0, 16'h0002);
        step();
        set_in(1'b1, 1'b1, 3'd4, 2'd0, 16'h0004);
        step();
        set_in(1'b0, 1'b0, 3'd0, 2'd0, 16'h0000);
        rd_addr_a = 3'd4; rd_addr_b = 3'd2;
        #1;
        chk_val("haz_hit_a", 32'(hit_a), 32'd1);
        chk_val("haz_hit_b", 32'(hit_b), 32'd0);

        // Flush after loading 0xBEEF.
        set_in(1'b1, 1'b1, 3'd5, 2'd1, 16'hBEEF);
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
`ifdef MEM_WB_CLR_DATA_EN
        chk_val("clr_mem", 32'(mem_data_out), 32'h0000);
`else
        chk_val("flush_beef_valid", 32'(valid_out), 32'd0);
`endif

        // Random traffic, including reset/flush/stall collisions.
        for (int n = 0; n < 300; n++) begin
            rst   = ($urandom_range(0, 39) == 0);
            flush = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            valid_in    = ($urandom_range(0, 3) != 0);
            RegWrt_in   = $urandom_range(0, 1) == 1;
            WrtReg_in   = REG_W'($urandom_range(0, 7));
            RegSrc_in   = 2'($urandom_range(0, 3));
            MemRead_in  = DATA_W'($urandom);
            alu_data_in = DATA_W'($urandom);
            pc_data_in  = DATA_W'($urandom);
            Binput_in   = DATA_W'($urandom);
            rd_addr_a   = REG_W'($urandom_range(0, 7));
            rd_addr_b   = REG_W'($urandom_range(0, 7));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
